wishbone_interconnect_n: RTL and testbench

WISHBONE_INTERCONNECT_N -- requirements
Module: wishbone_interconnect_n

---
 rtl/wishbone_interconnect_n.sv | 181 ++++++++++++++++++
 tb/tb_wishbone_interconnect_n.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_interconnect_n.sv
// Single-master to N-slave Wishbone interconnect.
// Decodes the master address to one slave (lowest matching index wins),
// registers the request toward the slaves, and terminates the cycle on the
// selected slave's ack/err or on a BUSY timeout. Error terminations are counted.
module wishbone_interconnect_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hFFFF_F000}},
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  // master side
  input  logic [ADDR_W-1:0]            m_adr_i,
  input  logic [DATA_W-1:0]            m_dat_i,
  output logic [DATA_W-1:0]            m_dat_o,
  input  logic                         m_we_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  input  logic [SEL_W-1:0]             m_sel_i,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  // slave side
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic                         s_we_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  input  logic [NUM_SLAVES-1:0]        s_err_i,
  // status
  output logic [15:0]                  err_cnt_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_SLAVES-1:0]   strobe_q;
  logic [15:0]             tmo_q;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_vec;

  logic                    start;
  logic                    dec_err;
  logic                    term_ack;
  logic                    term_err;
  logic                    abort;
  logic                    tmo_hit;

  // Cycle and strobe toward each slave are the same one-hot register.
  assign s_cyc_o = strobe_q;
  assign s_stb_o = strobe_q;

  // The current BUSY cycle is the TIMEOUT-th one when the counter reads TIMEOUT-1.
  assign tmo_hit = (tmo_q == 16'(TIMEOUT - 1));

  // Address decode: scan from the top so the lowest matching slave is kept.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    hit_vec = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit        = 1'b1;
        hit_idx    = IDX_W'(i);
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and transaction control decisions.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    dec_err  = 1'b0;
    term_ack = 1'b0;
    term_err = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (hit) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            dec_err = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Master dropping the cycle wins: it is no longer listening for a reply.
        if (!m_cyc_i) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (s_err_i[idx_q]) begin
          term_err = 1'b1;
          state_d  = ST_RESP;
        end else if (s_ack_i[idx_q]) begin
          term_ack = 1'b1;
          state_d  = ST_RESP;
        end else if (tmo_hit) begin
          term_err = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers, strobes, termination pulses, read data and counters.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data-path registers are reset too, because their values are
    // visible on the ports and must read zero while reset is held.
    if (!rst) begin
      idx_q     <= '0;
      strobe_q  <= '0;
      tmo_q     <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      m_ack_o   <= 1'b0;
      m_err_o   <= 1'b0;
      m_dat_o   <= '0;
      err_cnt_o <= '0;
    end else begin
      m_ack_o <= term_ack;
      m_err_o <= term_err | dec_err;

      if (start) begin
        idx_q    <= hit_idx;
        strobe_q <= hit_vec;
        s_adr_o  <= m_adr_i;
        s_dat_o  <= m_dat_i;
        s_we_o   <= m_we_i;
        s_sel_o  <= m_sel_i;
        tmo_q    <= '0;
      end else if (state_q == ST_BUSY) begin
        tmo_q <= tmo_q + 16'd1;
      end

      if (term_ack || term_err || abort) strobe_q <= '0;

      // Only read acks update the returned data; writes and errors leave it.
      if (term_ack && !s_we_o) m_dat_o <= s_dat_i[int'(idx_q)*DATA_W +: DATA_W];

      if ((term_err || dec_err) && (err_cnt_o != 16'hFFFF))
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Bench for wishbone_interconnect_n: directed transactions plus randomized
// traffic, checked every cycle against a transaction-level model.
module tb_wishbone_interconnect_n;

  localparam int TMO = 8;
  // Slave 3 decodes 0x2000-0x3FFF, overlapping slave 2 on 0x2xxx.
  localparam logic [31:0] BASE_A [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  localparam logic [31:0] MASK_A [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000};

  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;
  localparam int K_ABORT = 4;

  logic         clk;
  logic         rst;
  logic [31:0]  m_adr, m_wdat, m_rdat;
  logic         m_we, m_cyc, m_stb, m_ack, m_err;
  logic [3:0]   m_sel;
  logic [31:0]  s_adr, s_wdat;
  logic         s_we;
  logic [3:0]   s_sel, s_cyc, s_stb, s_ack, s_err;
  logic [127:0] s_rdat;
  logic [15:0]  err_cnt;

  wishbone_interconnect_n #(
    .NUM_SLAVES (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE ({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
    .SLAVE_MASK ({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_wdat),
    .m_dat_o   (m_rdat),
    .m_we_i    (m_we),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_sel_i   (m_sel),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_wdat),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_dat_i   (s_rdat),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .err_cnt_o (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the master port must show this cycle.
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          check_en = 1'b0;
  logic [3:0]  exp_strobe = '0;
  logic        exp_ack = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_adr = '0, exp_wdat = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_sel = '0;
  logic [31:0] last_read = '0;
  logic [15:0] err_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int target_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASK_A[i]) == (BASE_A[i] & MASK_A[i])) return i;
    return -1;
  endfunction

  function automatic logic [3:0] noise(input int tgt, input bit flood);
    logic [3:0] n;
    n = flood ? 4'hF : (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    if (tgt >= 0) n[tgt] = 1'b0;
    return n;
  endfunction

  task automatic rand_sdat();
    for (int i = 0; i < 4; i++) s_rdat[i*32 +: 32] = $urandom;
  endtask

  task automatic bump_err();
    if (err_model != 16'hFFFF) err_model = err_model + 16'd1;
  endtask

  // One master transaction; the slave response is scripted by kind and r
  // (r = cycle, counted from the first strobe cycle as 1, in which the slave
  // answers or the master aborts).
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int kind, input int r,
                         input logic [31:0] rsp_dat, input bit flood);
    int tgt, term;
    bit is_tmo;
    tgt = target_of(adr);
    m_adr = adr; m_we = we; m_wdat = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    s_ack = noise(tgt, flood); s_err = noise(tgt, flood); rand_sdat();
    exp_strobe = '0; exp_ack = 1'b0; exp_err = 1'b0;
    next_cycle();
    if (tgt < 0) begin
      m_cyc = 1'b0; m_stb = 1'b0;
      s_ack = noise(-1, flood); s_err = noise(-1, flood); rand_sdat();
      exp_err = 1'b1; bump_err();
      next_cycle();
      exp_err = 1'b0;
      return;
    end
    is_tmo = (kind == K_NONE) || (kind != K_ABORT && r > TMO);
    term   = is_tmo ? TMO : r;
    exp_adr = adr; exp_wdat = wdat; exp_we = we; exp_sel = sel;
    for (int c = 1; c <= term; c++) begin
      exp_strobe = 4'(1) << tgt;
      s_ack = noise(tgt, flood); s_err = noise(tgt, flood); rand_sdat();
      if (c == term && !is_tmo) begin
        if (kind == K_ABORT) begin
          m_cyc = 1'b0; m_stb = 1'b0;
        end else begin
          s_rdat[tgt*32 +: 32] = rsp_dat;
          s_ack[tgt] = (kind == K_ACK || kind == K_BOTH);
          s_err[tgt] = (kind == K_ERR || kind == K_BOTH);
        end
      end
      next_cycle();
    end
    m_cyc = 1'b0; m_stb = 1'b0; exp_strobe = '0;
    s_ack = noise(tgt, flood); s_err = noise(tgt, flood); rand_sdat();
    if (kind == K_ABORT) return;
    if (!is_tmo && kind == K_ACK) begin
      exp_ack = 1'b1;
      if (!we) last_read = rsp_dat;
    end else begin
      exp_err = 1'b1; bump_err();
    end
    next_cycle();
    exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("s_stb",   64'(s_stb),   64'(exp_strobe));
      check("s_cyc",   64'(s_cyc),   64'(exp_strobe));
      check("m_ack",   64'(m_ack),   64'(exp_ack));
      check("m_err",   64'(m_err),   64'(exp_err));
      check("m_dat",   64'(m_rdat),  64'(last_read));
      check("err_cnt", 64'(err_cnt), 64'(err_model));
      if (exp_strobe != 4'b0) begin
        check("s_adr", 64'(s_adr),  64'(exp_adr));
        check("s_dat", 64'(s_wdat), 64'(exp_wdat));
        check("s_we",  64'(s_we),   64'(exp_we));
        check("s_sel", 64'(s_sel),  64'(exp_sel));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    int kind, r;
    rst = 1'b0;
    m_adr = '0; m_wdat = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_sel = '0;
    s_ack = '0; s_err = '0; s_rdat = '0;
    #12;
    check("rst_stb",   64'(s_stb),   64'h0);
    check("rst_ack",   64'(m_ack),   64'h0);
    check("rst_err",   64'(m_err),   64'h0);
    check("rst_mdat",  64'(m_rdat),  64'h0);
    check("rst_cnt",   64'(err_cnt), 64'h0);
    check("rst_sadr",  64'(s_adr),   64'h0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    check_en = 1'b1;

    // Read 0x1004, slave 1 acks in the third strobe cycle.
    run_txn(32'h0000_1004, 1'b0, 32'h0, 4'hF, K_ACK, 3, 32'hDEAD_BEEF, 1'b0);
    check("pin_read_data", 64'(m_rdat), 64'hDEAD_BEEF);
    // Write 0x3010 to slave 3; read data must not move.
    run_txn(32'h0000_3010, 1'b1, 32'h0000_005A, 4'b0001, K_ACK, 1, 32'h1234_5678, 1'b0);
    check("pin_wr_mdat", 64'(m_rdat), 64'hDEAD_BEEF);
    check("pin_wr_sadr", 64'(s_adr),  64'h3010);
    check("pin_wr_sdat", 64'(s_wdat), 64'h5A);
    check("pin_wr_swe",  64'(s_we),   64'h1);
    check("pin_wr_ssel", 64'(s_sel),  64'h1);
    // Unmapped access.
    run_txn(32'h0000_8000, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0, 1'b0);
    check("pin_dec_cnt", 64'(err_cnt), 64'd1);
    // Slave 2 never answers.
    run_txn(32'h0000_2000, 1'b0, 32'h0, 4'hF, K_NONE, 0, 32'h0, 1'b0);
    check("pin_tmo_cnt", 64'(err_cnt), 64'd2);
    // Slave 0 ack+err together, every other slave acking and erroring.
    run_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, K_BOTH, 2, 32'h5555_5555, 1'b1);
    check("pin_both_cnt",  64'(err_cnt), 64'd3);
    check("pin_both_mdat", 64'(m_rdat),  64'hDEAD_BEEF);
    // Ack exactly on the timeout cycle, then one cycle too late.
    run_txn(32'h0000_2100, 1'b0, 32'h0, 4'hF, K_ACK, TMO, 32'hA5A5_0001, 1'b0);
    check("pin_edge_ack", 64'(m_rdat), 64'hA5A5_0001);
    run_txn(32'h0000_3100, 1'b0, 32'h0, 4'hF, K_ACK, TMO + 1, 32'hA5A5_0002, 1'b0);
    check("pin_late_cnt", 64'(err_cnt), 64'd4);
    // Master abort.
    run_txn(32'h0000_1000, 1'b1, 32'hFFFF_0000, 4'hC, K_ABORT, 2, 32'h0, 1'b0);
    check("pin_abort_cnt", 64'(err_cnt), 64'd4);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) < 8)
        adr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 1023)) << 2);
      else
        adr = $urandom | 32'h0001_0000;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: kind = K_ACK;
        4:          kind = K_ERR;
        5:          kind = K_BOTH;
        6:          kind = K_NONE;
        default:    kind = K_ABORT;
      endcase
      r = (kind == K_ABORT) ? $urandom_range(1, TMO) : $urandom_range(1, TMO + 2);
      run_txn(adr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              kind, r, $urandom, 1'($urandom_range(0, 7) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        s_ack = noise(-1, 1'b0); s_err = noise(-1, 1'b0); rand_sdat();
        next_cycle();
      end
    end

    // Asynchronous reset in the middle of a BUSY transaction.
    s_ack = '0; s_err = '0;
    m_adr = 32'h0000_2040; m_we = 1'b0; m_wdat = 32'h0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    exp_strobe = '0;
    next_cycle();
    exp_strobe = 4'b0100; exp_adr = 32'h0000_2040; exp_we = 1'b0; exp_wdat = 32'h0; exp_sel = 4'hF;
    next_cycle();
    #2;
    check_en = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_stb",  64'(s_stb),   64'h0);
    check("arst_cyc",  64'(s_cyc),   64'h0);
    check("arst_ack",  64'(m_ack),   64'h0);
    check("arst_err",  64'(m_err),   64'h0);
    check("arst_mdat", 64'(m_rdat),  64'h0);
    check("arst_cnt",  64'(err_cnt), 64'h0);
    check("arst_sadr", 64'(s_adr),   64'h0);
    check("arst_sdat", 64'(s_wdat),  64'h0);
    check("arst_swe",  64'(s_we),    64'h0);
    check("arst_ssel", 64'(s_sel),   64'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    next_cycle();
    check("arst_hold_stb", 64'(s_stb), 64'h0);
    check("arst_hold_ack", 64'(m_ack), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    last_read = '0; err_model = '0;
    exp_strobe = '0; exp_ack = 1'b0; exp_err = 1'b0;
    next_cycle();
    check_en = 1'b1;
    run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, K_ACK, 2, 32'hCAFE_F00D, 1'b0);
    check("post_rst_rdata", 64'(m_rdat), 64'hCAFE_F00D);
    next_cycle();
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
